// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller.
// Holds the FSM state enum, the ALUControl/ResultSrc/ALUSrc select encodings,
// the Op/cmd field constants and the condition-code evaluation helper.
// Optional feature macro used by the importing RTL: MULTICYCLE_CTRL_CMP_EN.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Instruction class (Op) values
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Data-processing cmd values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition-code check; flags ordered {N,Z,C,V}. Code 1111 never executes.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic ge;
        logic res;
        n  = flags[3];
        z  = flags[2];
        c  = flags[1];
        v  = flags[0];
        ge = (n == v);
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = ~z & c;
            4'b1001: res = z | ~c;
            4'b1010: res = ge;
            4'b1011: res = ~ge;
            4'b1100: res = ~z & ge;
            4'b1101: res = z | ~ge;
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mainfsm.sv
// mc_mainfsm: state register and per-state decode of the multicycle controller.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   op_i            instruction class
//   imm_i           Funct[5] (immediate operand)
//   ls_i            Funct[0] (load when 1, store when 0 for memory ops)
//   state_o         current state
//   next_pc_o, branch_o, reg_w_o, mem_w_o, ir_write_o   ungated per-state strobes
//   adr_src_o, alu_src_a_o, alu_src_b_o, result_src_o    datapath selects
//   alu_op_o        1 in the execute states
// Outputs are a pure function of the state (Moore).
module mc_mainfsm
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op_i,
    input  logic       imm_i,
    input  logic       ls_i,
    output state_e     state_o,
    output logic       next_pc_o,
    output logic       branch_o,
    output logic       reg_w_o,
    output logic       mem_w_o,
    output logic       ir_write_o,
    output logic       adr_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic       alu_op_o
);

    state_e state_q;
    state_e state_d;

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = imm_i ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = ls_i ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state output decode
    always_comb begin
        next_pc_o    = 1'b0;
        branch_o     = 1'b0;
        reg_w_o      = 1'b0;
        mem_w_o      = 1'b0;
        ir_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        alu_src_a_o  = SRCA_RD1;
        alu_src_b_o  = SRCB_RD2;
        result_src_o = RES_ALUOUT;
        alu_op_o     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_o   = 1'b1;
                next_pc_o    = 1'b1;
                alu_src_a_o  = SRCA_PC;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALURESULT;
            end
            S_DECODE: begin
                alu_src_a_o  = SRCA_PC;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALURESULT;
            end
            S_MEMADR: alu_src_b_o = SRCB_EXTIMM;
            S_MEMREAD: adr_src_o = 1'b1;
            S_MEMWB: begin
                result_src_o = RES_DATA;
                reg_w_o      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o = 1'b1;
                mem_w_o   = 1'b1;
            end
            S_EXECUTER: alu_op_o = 1'b1;
            S_EXECUTEI: begin
                alu_src_b_o = SRCB_EXTIMM;
                alu_op_o    = 1'b1;
            end
            S_ALUWB: reg_w_o = 1'b1;
            S_BRANCH: begin
                alu_src_a_o  = SRCA_ALUOUT;
                alu_src_b_o  = SRCB_EXTIMM;
                result_src_o = RES_ALURESULT;
                branch_o     = 1'b1;
            end
            default: begin
                next_pc_o = 1'b0;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control unit of a multicycle ARM-subset processor.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   Cond, Op, Funct, Rd   instruction fields
//   ALUFlags     {N,Z,C,V} from the ALU
//   PCWrite, MemWrite, RegWrite, IRWrite   write enables (forced 0 in reset)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl   selects
// Sequencing lives in mc_mainfsm; ALU decode, flag storage and conditional
// gating live here.
// Optional macro MULTICYCLE_CTRL_CMP_EN: cmd=1010 with S=1 becomes CMP
// (SUB, all four flags written, no register write-back).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl
);

    state_e     state_s;
    logic       next_pc_s;
    logic       branch_s;
    logic       reg_w_s;
    logic       reg_w_eff_s;
    logic       mem_w_s;
    logic       ir_write_s;
    logic       alu_op_s;
    logic [3:0] cmd_s;
    logic       s_bit_s;
    logic [1:0] flag_w_s;
    logic [1:0] alu_control_s;
    logic       cond_ex_s;
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex_r_q;
    logic       cond_ex_r_d;

    assign cmd_s   = Funct[4:1];
    assign s_bit_s = Funct[0];

    mc_mainfsm u_mainfsm (
        .clk          (clk),
        .reset        (reset),
        .op_i         (Op),
        .imm_i        (Funct[5]),
        .ls_i         (Funct[0]),
        .state_o      (state_s),
        .next_pc_o    (next_pc_s),
        .branch_o     (branch_s),
        .reg_w_o      (reg_w_s),
        .mem_w_o      (mem_w_s),
        .ir_write_o   (ir_write_s),
        .adr_src_o    (AdrSrc),
        .alu_src_a_o  (ALUSrcA),
        .alu_src_b_o  (ALUSrcB),
        .result_src_o (ResultSrc),
        .alu_op_o     (alu_op_s)
    );

    // ALU operation and flag-write decode (only active in the execute states)
    always_comb begin
        alu_control_s = ALU_ADD;
        flag_w_s      = 2'b00;
        if (alu_op_s) begin
            case (cmd_s)
                CMD_ADD: alu_control_s = ALU_ADD;
                CMD_SUB: alu_control_s = ALU_SUB;
                CMD_AND: alu_control_s = ALU_AND;
                CMD_ORR: alu_control_s = ALU_ORR;
`ifdef MULTICYCLE_CTRL_CMP_EN
                CMD_CMP: alu_control_s = s_bit_s ? ALU_SUB : ALU_ADD;
`endif
                default: alu_control_s = ALU_ADD;
            endcase
            flag_w_s[1] = s_bit_s;
            flag_w_s[0] = s_bit_s & ((cmd_s == CMD_ADD) | (cmd_s == CMD_SUB));
`ifdef MULTICYCLE_CTRL_CMP_EN
            if ((cmd_s == CMD_CMP) && s_bit_s) begin
                flag_w_s = 2'b11;
            end else begin
                flag_w_s = flag_w_s;
            end
`endif
        end else begin
            alu_control_s = ALU_ADD;
            flag_w_s      = 2'b00;
        end
    end

    // Register write-back strobe; a compare only sets flags
    always_comb begin
        reg_w_eff_s = reg_w_s;
`ifdef MULTICYCLE_CTRL_CMP_EN
        if ((Op == OP_DP) && (cmd_s == CMD_CMP) && s_bit_s) begin
            reg_w_eff_s = 1'b0;
        end else begin
            reg_w_eff_s = reg_w_s;
        end
`endif
    end

    assign cond_ex_s = cond_check(Cond, flags_q);

    // Flag and latched-condition next values; {N,Z} and {C,V} load separately
    always_comb begin
        flags_d     = flags_q;
        cond_ex_r_d = cond_ex_r_q;
        if (flag_w_s[1] & cond_ex_r_q) begin
            flags_d[3:2] = ALUFlags[3:2];
        end else begin
            flags_d[3:2] = flags_q[3:2];
        end
        if (flag_w_s[0] & cond_ex_r_q) begin
            flags_d[1:0] = ALUFlags[1:0];
        end else begin
            flags_d[1:0] = flags_q[1:0];
        end
        // Condition is sampled once per instruction, at the end of DECODE
        if (state_s == S_DECODE) begin
            cond_ex_r_d = cond_ex_s;
        end else begin
            cond_ex_r_d = cond_ex_r_q;
        end
    end

    // Flag register and latched condition, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            cond_ex_r_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            cond_ex_r_q <= cond_ex_r_d;
        end
    end

    // Write enables are gated by the latched condition and killed during reset
    assign RegWrite = ~reset & reg_w_eff_s & cond_ex_r_q;
    assign MemWrite = ~reset & mem_w_s & cond_ex_r_q;
    assign IRWrite  = ~reset & ir_write_s;
    assign PCWrite  = ~reset & (next_pc_s
                              | (branch_s & cond_ex_r_q)
                              | (reg_w_eff_s & cond_ex_r_q & (Rd == 4'd15)));

    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == OP_MEM), (Op == OP_BR)};
    assign ALUControl = alu_control_s;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] ALUControl;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
    function automatic logic [16:0] v(input logic pcw, input logic mw, input logic rw,
                                      input logic irw, input logic adr, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] res, input logic [1:0] imm,
                                      input logic [1:0] aluc);
        return {pcw, mw, rw, irw, adr, rs, sa, sb, res, imm, aluc};
    endfunction

    function automatic logic [16:0] obs();
        return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ImmSrc, ALUControl};
    endfunction

    task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r, input logic [3:0] fl);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        Cond = 4'b1110; Op = 2'b00; Funct = 6'b001000; Rd = 4'd1; ALUFlags = 4'b0000;
        step();
        chk("reset_outputs", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));
        chk("reset_flags", {13'd0, dut.flags_q}, 17'd0);
        step();
        reset = 1'b0;

        // ADD r1: FETCH, DECODE, EXECUTER, ALUWB
        instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000);
        chk("add_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));
        step();
        chk("add_decode", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));
        step();
        chk("add_exec", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
        step();
        chk("add_aluwb", obs(), v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
        step();

        // SUBS r1 with ALU reporting Z
        instr(4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0100);
        chk("subs_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));
        step();
        step();
        chk("subs_exec", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b01));
        step();
        chk("subs_aluwb", obs(), v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
        chk("subs_flags", {13'd0, dut.flags_q}, 17'h00004);
        step();

        // BEQ taken: 3 cycles, PCWrite in BRANCH
        instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        chk("beq_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b01,2'b01,2'b10,2'b10,2'b10,2'b00));
        step();
        chk("beq_decode", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b10,2'b10,2'b10,2'b00));
        step();
        chk("beq_branch", obs(), v(1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b01,2'b10,2'b10,2'b00));
        step();

        // BNE not taken
        instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
        chk("bne_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b01,2'b01,2'b10,2'b10,2'b10,2'b00));
        step();
        step();
        chk("bne_branch", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b01,2'b10,2'b10,2'b00));
        step();

        // LDR r2: 5 cycles
        instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000);
        chk("ldr_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));
        step();
        step();
        chk("ldr_memadr", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,2'b01,2'b00));
        step();
        chk("ldr_memread", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,2'b01,2'b00));
        step();
        chk("ldr_memwb", obs(), v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,2'b00,2'b00,2'b01,2'b01,2'b00));
        step();

        // STRNE while Z=1: no memory write, back in FETCH after 4 cycles
        instr(4'b0001, 2'b01, 6'b011000, 4'd2, 4'b0000);
        chk("strne_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));
        step();
        step();
        step();
        chk("strne_memwrite", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,2'b01,2'b00));
        step();

        // ADD pc: write-back also writes the PC
        instr(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
        chk("addpc_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));
        step();
        step();
        step();
        chk("addpc_aluwb", obs(), v(1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
        step();

        // Op=11: two cycles, no side effects
        instr(4'b1110, 2'b11, 6'b000000, 4'd5, 4'b1111);
        chk("nop_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b10,2'b11,2'b00));
        step();
        chk("nop_decode", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b10,2'b11,2'b00));
        step();
        chk("flags_held", {13'd0, dut.flags_q}, 17'h00004);

        // STR, then reset in MEMWRITE
        instr(4'b1110, 2'b01, 6'b011000, 4'd4, 4'b0000);
        chk("str_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));
        step();
        step();
        step();
        chk("str_memwrite", obs(), v(1'b0,1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,2'b01,2'b00));
        reset = 1'b1;
        #1;
        chk("str_reset_kill", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,2'b01,2'b00));
        step();
        chk("post_reset_state", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,2'b10,2'b01,2'b00));
        chk("post_reset_flags", {13'd0, dut.flags_q}, 17'd0);
        reset = 1'b0;

        // cmd=1010 with S=1, ALU reporting {N,Z,C,V}=1011
        instr(4'b1110, 2'b00, 6'b010101, 4'd3, 4'b1011);
        chk("cmp_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));
        step();
        step();
`ifdef MULTICYCLE_CTRL_CMP_EN
        chk("cmp_exec", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b01));
        step();
        chk("cmp_aluwb", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
        chk("cmp_flags", {13'd0, dut.flags_q}, 17'h0000b);
`else
        chk("cmp_exec", obs(), v(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
        step();
        chk("cmp_aluwb", obs(), v(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00));
        chk("cmp_flags", {13'd0, dut.flags_q}, 17'h00008);
`endif
        step();
        chk("final_fetch", obs(), v(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b10,2'b10,2'b00,2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
